ibex_input_debounce: RTL and testbench
======================================

# ibex_input_debounce

Board-input conditioning stage between the Arty A7 pins (BTN, SW) and the logic that consumes them inside the FPGA top. It does three things for every input bit:
- synchronises the asynchronous pin into `clk_sys`;
- debounces it with a per-bit stability counter;
- produces one-cycle rise/fall strobes and a sticky, write-1-to-clear pending bitmap with a single interrupt line for the demo system.

## Interface
Parameters:
- `Width`, default 8: number of input bits (BTN[3:0] and SW[3:0] concatenated).
- `DebounceCycles`, default 50000: consecutive stable cycles required to accept a change (1 ms at 50 MHz). Legal range is at least 1.

Ports:
- `clk_sys_i`  input  1  system clock.
- `rst_sys_i`  input  1  reset; one clock, synchronous, active-high.
- `raw_i`  input  Width  asynchronous board inputs.
- `state_o`  output  Width  debounced level.
- `rise_o`  output  Width  one-cycle strobe on an accepted 0→1 change.
- `fall_o`  output  Width  one-cycle strobe on an accepted 1→0 change.
- `pending_o`  output  Width  sticky record of accepted rises.
- `clear_i`  input  Width  write-1-to-clear mask for `pending_o`.
- `irq_o`  output  1  OR-reduction of `pending_o`.

## Operation
- Synchroniser: two flops per bit; `sync` denotes the second flop output. Both flops reset to 0.
- Per-bit counter:
  - Width is $clog2(DebounceCycles+1).
  - When `sync` equals `state_o`, the counter loads 0.
  - When `sync` differs from `state_o`, the counter increments.
  - When the counter equals DebounceCycles-1 while `sync` still differs, at the next edge `state_o` toggles and the counter loads 0.
  - Any single cycle where `sync` equals `state_o` restarts the count. A glitch shorter than DebounceCycles is never accepted.
- Strobes: `rise_o` and `fall_o` are registered and asserted in the same cycle `state_o` first shows the new value, for exactly one cycle.
- Pending: `pending_o[i]` is set by `rise_o[i]` and cleared by `clear_i[i]`. If set and clear hit the same bit in the same cycle, set wins. Clearing a bit that is already 0 has no effect.
- `irq_o` is a registered OR of the next-state `pending`, so it changes in the same cycle as `pending_o`.
- All bits are fully independent; no cross-bit interaction.
- Reset values: every flop, counter, `state_o`, `rise_o`, `fall_o`, `pending_o` and `irq_o` is 0.
- An input held high through reset is accepted as a rise after reset deasserts. It then sets pending; this is intended, so a button held at boot is reported.
- Reset mid-count discards the partial count. Reset during a strobe drops the strobe on the next edge.

## Timing
- Latency from a pin change (sampled at edge t) to `state_o` change:
  - `sync` shows the change at t+2;
  - `state_o`, `rise_o`/`fall_o` show it at t+2+DebounceCycles;
  - `pending_o`/`irq_o` show it at t+3+DebounceCycles.
- `clear_i` takes effect at the next edge. `irq_o` falls in that same cycle if no other bit is pending.
- DebounceCycles = 1: `state_o` follows `sync` with one cycle of delay; any change persisting for one cycle is accepted.
- The counter never wraps. It is bounded at DebounceCycles-1 by the accept/restart rule.
- Throughput: back-to-back accepted toggles on one bit are at least DebounceCycles cycles apart.

## Test plan
All scenarios use Width=8 and DebounceCycles=4.
- Reset with `raw_i`=0 → all outputs 0. Raise `raw_i[0]` at edge 10 → `state_o[0]`=1 and `rise_o`=8'h01 for exactly one cycle at edge 16, `pending_o`=8'h01 and `irq_o`=1 at edge 17.
- Glitch of 3 cycles on `raw_i[3]`, then return to 0 → `state_o`, `rise_o`, `fall_o` and `pending_o` stay 0 throughout.
- Bounce pattern 1,0,1,1,1,1 on `raw_i[2]` → exactly one `rise_o[2]` strobe, issued 4 cycles after the final stable 1 reaches `sync`. Release for 4+ cycles → exactly one `fall_o[2]` strobe; `pending_o` is unchanged by the fall.
- With `pending_o`=8'h05, pulse `clear_i`=8'h01 → `pending_o`=8'h04 and `irq_o`=1. Then `clear_i`=8'h04 in the same cycle as a new `rise_o[2]` → `pending_o[2]` stays 1 (set wins).
- Hold `raw_i`=8'hFF through reset → 6 cycles after reset deasserts, `state_o`=8'hFF and `rise_o`=8'hFF for one cycle; the next cycle `pending_o`=8'hFF.
- Assert reset 2 cycles into a count on bit 1 → all state is cleared. After reset the count restarts from 0 and the rise arrives 2+4 cycles after reset release.

Source files
------------

// File: rtl/ibex_input_debounce_if.sv
// Signal bundle between the board-input conditioner and its consumer.
// The master side drives pins and clears. The slave side is the conditioner.
interface ibex_input_debounce_if #(
  parameter int Width = 8
);
  logic [Width-1:0] raw_i;
  logic [Width-1:0] clear_i;
  logic [Width-1:0] state_o;
  logic [Width-1:0] rise_o;
  logic [Width-1:0] fall_o;
  logic [Width-1:0] pending_o;
  logic             irq_o;

  modport master (
    output raw_i,
    output clear_i,
    input  state_o,
    input  rise_o,
    input  fall_o,
    input  pending_o,
    input  irq_o
  );

  modport slave (
    input  raw_i,
    input  clear_i,
    output state_o,
    output rise_o,
    output fall_o,
    output pending_o,
    output irq_o
  );
endinterface

// File: rtl/ibex_input_debounce.sv
// Board-input conditioner: per-bit two-flop synchroniser, stability-counter debounce,
// registered rise/fall strobes and a sticky write-1-to-clear pending map with IRQ.
module ibex_input_debounce #(
  parameter int Width          = 8,
  parameter int DebounceCycles = 50000
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_i,
  ibex_input_debounce_if.slave bus
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [Width-1:0] meta_q, meta_d;
  logic [Width-1:0] sync_q, sync_d;
  logic [Width-1:0] state_q, state_d;
  logic [Width-1:0] rise_q, rise_d;
  logic [Width-1:0] fall_q, fall_d;
  logic [Width-1:0] pending_q, pending_d;
  logic             irq_q, irq_d;
  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];

  // Next-state logic: debounce counters, strobes and pending bookkeeping.
  always_comb begin
    meta_d  = bus.raw_i;
    sync_d  = meta_q;
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < Width; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        // Change has been stable long enough: accept it and restart counting.
        cnt_d[i]   = '0;
        state_d[i] = sync_q[i];
        rise_d[i]  = sync_q[i];
        fall_d[i]  = ~sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
    // A rise in the same cycle as a clear keeps the bit set.
    pending_d = (pending_q & ~bus.clear_i) | rise_q;
    irq_d     = |pending_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      meta_q    <= '0;
      sync_q    <= '0;
      state_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.state_o   = state_q;
  assign bus.rise_o    = rise_q;
  assign bus.fall_o    = fall_q;
  assign bus.pending_o = pending_q;
  assign bus.irq_o     = irq_q;

endmodule

// File: tb/tb_ibex_input_debounce.sv
// Directed bench for ibex_input_debounce (Width=8, DebounceCycles=4) with a
// window-based reference model checked every cycle plus hand-computed expectations.
module tb_ibex_input_debounce;
  localparam int W  = 8;
  localparam int DC = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ibex_input_debounce_if #(.Width(W)) dut_if ();

  ibex_input_debounce #(
    .Width         (W),
    .DebounceCycles(DC)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_i(rst),
    .bus      (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted when the last DC synchronised samples
  // all disagree with the current debounced level.
  logic [W-1:0]  m_s1, m_s2, m_state, m_rise, m_fall, m_pending;
  logic          m_irq;
  logic [DC-1:0] m_hist [W];
  logic [DC-1:0] all_ones;
  logic [DC-1:0] all_zeros;

  task automatic model_edge();
    logic [W-1:0] nstate, nrise, nfall, npend;
    logic [DC-1:0] target;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_state = '0; m_rise = '0; m_fall = '0;
      m_pending = '0; m_irq = 1'b0;
      for (int i = 0; i < W; i++) m_hist[i] = '0;
    end else begin
      npend  = (m_pending & ~dut_if.clear_i) | m_rise;
      nstate = m_state;
      nrise  = '0;
      nfall  = '0;
      for (int i = 0; i < W; i++) begin
        m_hist[i] = {m_hist[i][DC-2:0], m_s2[i]};
        target = m_state[i] ? all_zeros : all_ones;
        if (m_hist[i] == target) begin
          nstate[i] = ~m_state[i];
          nrise[i]  = ~m_state[i];
          nfall[i]  = m_state[i];
        end
      end
      m_s2      = m_s1;
      m_s1      = dut_if.raw_i;
      m_state   = nstate;
      m_rise    = nrise;
      m_fall    = nfall;
      m_pending = npend;
      m_irq     = |npend;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_state",   32'(dut_if.state_o),   32'(m_state));
    check("model_rise",    32'(dut_if.rise_o),    32'(m_rise));
    check("model_fall",    32'(dut_if.fall_o),    32'(m_fall));
    check("model_pending", 32'(dut_if.pending_o), 32'(m_pending));
    check("model_irq",     32'(dut_if.irq_o),     32'(m_irq));
  endtask

  // Advance n cycles: model updates at the active edge, comparison on the falling edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_model();
    end
  endtask

  initial begin
    logic [5:0] bounce;
    n_checks  = 0;
    n_fail    = 0;
    all_ones  = '1;
    all_zeros = '0;
    m_s1 = '0; m_s2 = '0; m_state = '0; m_rise = '0; m_fall = '0;
    m_pending = '0; m_irq = 1'b0;
    for (int i = 0; i < W; i++) m_hist[i] = '0;

    rst = 1'b1;
    dut_if.raw_i   = 8'h00;
    dut_if.clear_i = 8'h00;
    step(3);
    rst = 1'b0;
    check("reset_state",   32'(dut_if.state_o),   32'h00);
    check("reset_rise",    32'(dut_if.rise_o),    32'h00);
    check("reset_fall",    32'(dut_if.fall_o),    32'h00);
    check("reset_pending", 32'(dut_if.pending_o), 32'h00);
    check("reset_irq",     32'(dut_if.irq_o),     32'h0);
    step(2);

    // Rise on bit 0: accepted DC+2 cycles after the pin is first captured.
    dut_if.raw_i = 8'h01;
    step(5);
    check("b0_not_yet", 32'(dut_if.state_o), 32'h00);
    step(1);
    check("b0_state",   32'(dut_if.state_o),   32'h01);
    check("b0_rise",    32'(dut_if.rise_o),    32'h01);
    check("b0_pend_lag", 32'(dut_if.pending_o), 32'h00);
    step(1);
    check("b0_rise_one", 32'(dut_if.rise_o),    32'h00);
    check("b0_pending",  32'(dut_if.pending_o), 32'h01);
    check("b0_irq",      32'(dut_if.irq_o),     32'h1);

    // Three-cycle glitch on bit 3 is rejected.
    dut_if.raw_i = 8'h09;
    step(3);
    dut_if.raw_i = 8'h01;
    step(8);
    check("glitch_state",   32'(dut_if.state_o),   32'h01);
    check("glitch_pending", 32'(dut_if.pending_o), 32'h01);

    // Bounce 1,0,1,1,1,1 on bit 2, then hold.
    bounce = 6'b111101;
    for (int k = 0; k < 6; k++) begin
      dut_if.raw_i = {5'b00000, bounce[k], 2'b01};
      step(1);
    end
    step(1);
    check("bounce_not_yet", 32'(dut_if.state_o), 32'h01);
    step(1);
    check("bounce_state", 32'(dut_if.state_o), 32'h05);
    check("bounce_rise",  32'(dut_if.rise_o),  32'h04);
    step(1);
    check("bounce_rise_one", 32'(dut_if.rise_o),    32'h00);
    check("bounce_pending",  32'(dut_if.pending_o), 32'h05);

    // Release bit 2: one fall strobe, pending untouched.
    dut_if.raw_i = 8'h01;
    step(5);
    check("fall_not_yet", 32'(dut_if.fall_o), 32'h00);
    step(1);
    check("fall_strobe",  32'(dut_if.fall_o),    32'h04);
    check("fall_state",   32'(dut_if.state_o),   32'h01);
    check("fall_pending", 32'(dut_if.pending_o), 32'h05);
    step(1);
    check("fall_one", 32'(dut_if.fall_o), 32'h00);

    // Write-1-to-clear and set-wins.
    dut_if.clear_i = 8'h01;
    step(1);
    dut_if.clear_i = 8'h00;
    check("clr_pending", 32'(dut_if.pending_o), 32'h04);
    check("clr_irq",     32'(dut_if.irq_o),     32'h1);
    dut_if.raw_i = 8'h05;
    step(6);
    check("sw_rise", 32'(dut_if.rise_o), 32'h04);
    dut_if.clear_i = 8'h04;
    step(1);
    dut_if.clear_i = 8'h00;
    check("set_wins", 32'(dut_if.pending_o), 32'h04);
    dut_if.clear_i = 8'h08;
    step(1);
    dut_if.clear_i = 8'h00;
    check("clr_zero_bit", 32'(dut_if.pending_o), 32'h04);
    dut_if.clear_i = 8'h04;
    step(1);
    dut_if.clear_i = 8'h00;
    check("clr_all_pending", 32'(dut_if.pending_o), 32'h00);
    check("clr_all_irq",     32'(dut_if.irq_o),     32'h0);

    // Reset two cycles into a count on bit 1.
    dut_if.raw_i = 8'h07;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_state",   32'(dut_if.state_o),   32'h00);
    check("mid_rst_pending", 32'(dut_if.pending_o), 32'h00);
    check("mid_rst_irq",     32'(dut_if.irq_o),     32'h0);
    step(5);
    check("mid_rst_not_yet", 32'(dut_if.state_o), 32'h00);
    step(1);
    check("mid_rst_state2", 32'(dut_if.state_o), 32'h07);
    check("mid_rst_rise",   32'(dut_if.rise_o),  32'h07);
    step(1);
    check("mid_rst_pend2", 32'(dut_if.pending_o), 32'h07);

    // All inputs held high through reset are reported after release.
    rst = 1'b1;
    dut_if.raw_i = 8'hFF;
    step(3);
    rst = 1'b0;
    check("held_reset_state", 32'(dut_if.state_o), 32'h00);
    step(5);
    check("held_not_yet", 32'(dut_if.state_o), 32'h00);
    step(1);
    check("held_state", 32'(dut_if.state_o),   32'hFF);
    check("held_rise",  32'(dut_if.rise_o),    32'hFF);
    check("held_pend0", 32'(dut_if.pending_o), 32'h00);
    step(1);
    check("held_rise_one", 32'(dut_if.rise_o),    32'h00);
    check("held_pending",  32'(dut_if.pending_o), 32'hFF);
    check("held_irq",      32'(dut_if.irq_o),     32'h1);
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
